pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) reports stage status; the controller (slave) returns enables and flushes.
interface pipeline_hazard_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        exmem_dREN;
  logic        exmem_dWEN;
  logic        idex_dREN;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        redirect;
  logic        halt_wb;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_freeze;
  logic        dmem_suppress;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN,
           idex_rt, ifid_rs, ifid_rt, redirect, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, idex_freeze, dmem_suppress,
           halted, stall_count
  );

  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN,
           idex_rt, ifid_rs, ifid_rt, redirect, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, idex_freeze, dmem_suppress,
           halted, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait sequencing, load-use bubbles,
// redirect flushes that survive fetch misses, halt, and a saturating stall counter.
module pipeline_hazard_ctrl (
  input  logic                   CLK,
  input  logic                   nRST,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic memop;
  logic lu;
  logic advance;
  logic flush;
  logic bubble;
  logic front_en;
  logic suppress;

  assign memop = bus.exmem_dREN | bus.exmem_dWEN;
  assign lu    = bus.idex_dREN & (bus.idex_rt != 5'd0) &
                 ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= RUN;
      redirect_pend_q <= 1'b0;
      halted_q        <= 1'b0;
      stall_count_q   <= 16'd0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
      halted_q        <= halted_d;
      stall_count_q   <= stall_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (memop && !bus.dhit)                  state_d = MEM_WAIT;
        else if (memop && bus.dhit && !bus.ihit) state_d = MEM_DONE;
      end
      MEM_WAIT: begin
        if (bus.dhit && bus.ihit)       state_d = RUN;
        else if (bus.dhit && !bus.ihit) state_d = MEM_DONE;
      end
      MEM_DONE: begin
        if (bus.ihit) state_d = RUN;
      end
      HALTED: state_d = HALTED;
    endcase
    if (bus.halt_wb) state_d = HALTED;
  end

  // A redirect seen while fetch is missing must still flush once the fetch lands
  always_comb begin
    redirect_pend_d = redirect_pend_q;
    if (bus.ihit)          redirect_pend_d = 1'b0;
    else if (bus.redirect) redirect_pend_d = 1'b1;
  end

  assign halted_d = (state_d == HALTED);

  // Output logic
  always_comb begin
    advance  = 1'b0;
    suppress = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    front_en = 1'b0;
    unique case (state_q)
      RUN:      advance = bus.ihit & (!memop | bus.dhit);
      MEM_WAIT: advance = bus.ihit & bus.dhit;
      MEM_DONE: begin
        advance  = bus.ihit;
        suppress = 1'b1;
      end
      HALTED:   advance = 1'b0;
    endcase
    if (state_q != HALTED) begin
      flush    = bus.redirect | redirect_pend_q;
      // Flushing discards the dependent instruction, so no bubble is needed
      bubble   = advance & lu & !flush;
      front_en = advance & !bubble;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q != HALTED) && !front_en && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  assign bus.pc_en         = front_en;
  assign bus.ifid_en       = front_en;
  assign bus.idex_en       = advance;
  assign bus.exmem_en      = advance;
  assign bus.memwb_en      = advance;
  assign bus.ifid_flush    = flush;
  assign bus.idex_flush    = flush;
  assign bus.idex_freeze   = bubble;
  assign bus.dmem_suppress = suppress;
  assign bus.halted        = halted_q;
  assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each task exercises one scenario with
// hand-computed expectations, sampling outputs mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en}
  logic [4:0] en_obs;
  // {ifid_flush, idex_flush, idex_freeze, dmem_suppress}
  logic [3:0] ctl_obs;
  assign en_obs  = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
  assign ctl_obs = {bus.ifid_flush, bus.idex_flush, bus.idex_freeze, bus.dmem_suppress};

  task automatic set_in(input logic ihit, input logic dhit, input logic dren, input logic dwen,
                        input logic idex_dren, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] frt, input logic redir, input logic halt);
    bus.ihit       = ihit;
    bus.dhit       = dhit;
    bus.exmem_dREN = dren;
    bus.exmem_dWEN = dwen;
    bus.idex_dREN  = idex_dren;
    bus.idex_rt    = rt;
    bus.ifid_rs    = rs;
    bus.ifid_rt    = frt;
    bus.redirect   = redir;
    bus.halt_wb    = halt;
  endtask

  task automatic idle();
    set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", bus.halted); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", bus.stall_count); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL rst_ctl: got %b expected 0000", ctl_obs); end
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL rst_en: got %b expected 11111", en_obs); end
    tick();
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL rst_hold_stall: got %0d expected 0", bus.stall_count); end
    nRST = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b00111) begin errors++; $display("FAIL lu_rs_en: got %b expected 00111", en_obs); end
    checks++; if (ctl_obs !== 4'b0010) begin errors++; $display("FAIL lu_rs_ctl: got %b expected 0010", ctl_obs); end
    tick();
    set_in(1, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL lu_after_en: got %b expected 11111", en_obs); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall1: got %0d expected 1", bus.stall_count); end
    tick();
    set_in(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL lu_r0_en: got %b expected 11111", en_obs); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL lu_r0_ctl: got %b expected 0000", ctl_obs); end
    tick();
    set_in(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b00111) begin errors++; $display("FAIL lu_rt_en: got %b expected 00111", en_obs); end
    checks++; if (ctl_obs !== 4'b0010) begin errors++; $display("FAIL lu_rt_ctl: got %b expected 0010", ctl_obs); end
    tick();
    set_in(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL lu_noihit_en: got %b expected 00000", en_obs); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL lu_noihit_ctl: got %b expected 0000", ctl_obs); end
    tick();
    set_in(1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL lu_flush_en: got %b expected 11111", en_obs); end
    checks++; if (ctl_obs !== 4'b1100) begin errors++; $display("FAIL lu_flush_ctl: got %b expected 1100", ctl_obs); end
    checks++; if (bus.stall_count !== 16'd3) begin errors++; $display("FAIL lu_stall3: got %0d expected 3", bus.stall_count); end
    tick();
    idle();
    #2;
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL lu_nopend_ctl: got %b expected 0000", ctl_obs); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_dmiss();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      #2;
      checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL dmiss_wait_en[%0d]: got %b expected 00000", i, en_obs); end
      tick();
    end
    set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL dmiss_hit_en: got %b expected 11111", en_obs); end
    checks++; if (bus.stall_count !== 16'd3) begin errors++; $display("FAIL dmiss_stall: got %0d expected 3", bus.stall_count); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL dmiss_hit_ctl: got %b expected 0000", ctl_obs); end
    tick();
    idle();
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL dmiss_run_en: got %b expected 11111", en_obs); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL dmiss_run_ctl: got %b expected 0000", ctl_obs); end
    tick();
    // MEM_WAIT resolving while fetch is still missing
    set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    tick();
    set_in(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL wait_done_en: got %b expected 00000", en_obs); end
    tick();
    set_in(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (ctl_obs !== 4'b0001) begin errors++; $display("FAIL wait_done_sup: got %b expected 0001", ctl_obs); end
    tick();
    set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL wait_done_adv: got %b expected 11111", en_obs); end
    tick();
    idle();
    #2;
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL wait_done_clr: got %b expected 0000", ctl_obs); end
    checks++; if (bus.stall_count !== 16'd6) begin errors++; $display("FAIL wait_done_stall: got %0d expected 6", bus.stall_count); end
    tick();
    $display("test_dmiss done");
  endtask

  task automatic test_dhit_first();
    do_reset();
    set_in(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL dfirst_en0: got %b expected 00000", en_obs); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL dfirst_ctl0: got %b expected 0000", ctl_obs); end
    tick();
    set_in(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (ctl_obs !== 4'b0001) begin errors++; $display("FAIL dfirst_sup: got %b expected 0001", ctl_obs); end
    checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL dfirst_en1: got %b expected 00000", en_obs); end
    tick();
    set_in(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL dfirst_adv: got %b expected 11111", en_obs); end
    checks++; if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL dfirst_stall: got %0d expected 2", bus.stall_count); end
    tick();
    idle();
    #2;
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL dfirst_clr: got %b expected 0000", ctl_obs); end
    tick();
    $display("test_dhit_first done");
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
      #2;
      checks++; if (ctl_obs !== 4'b1100) begin errors++; $display("FAIL redir_miss_ctl[%0d]: got %b expected 1100", i, ctl_obs); end
      checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL redir_miss_en[%0d]: got %b expected 00000", i, en_obs); end
      tick();
    end
    idle();
    #2;
    checks++; if (ctl_obs !== 4'b1100) begin errors++; $display("FAIL redir_pend_ctl: got %b expected 1100", ctl_obs); end
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL redir_pend_en: got %b expected 11111", en_obs); end
    tick();
    idle();
    #2;
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL redir_clr_ctl: got %b expected 0000", ctl_obs); end
    tick();
    $display("test_redirect done");
  endtask

  task automatic test_halt();
    do_reset();
    set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    tick();
    set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    #2;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", bus.halted); end
    tick();
    set_in(1, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    #2;
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", bus.halted); end
    checks++; if (en_obs !== 5'b00000) begin errors++; $display("FAIL halt_en: got %b expected 00000", en_obs); end
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL halt_ctl: got %b expected 0000", ctl_obs); end
    checks++; if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL halt_stall: got %0d expected 2", bus.stall_count); end
    tick();
    tick();
    checks++; if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL halt_frozen: got %0d expected 2", bus.stall_count); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_terminal: got %b expected 1", bus.halted); end
    idle();
    #2 nRST = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_rst_flag: got %b expected 0", bus.halted); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL halt_rst_stall: got %0d expected 0", bus.stall_count); end
    checks++; if (en_obs !== 5'b11111) begin errors++; $display("FAIL halt_rst_en: got %b expected 11111", en_obs); end
    tick();
    nRST = 1'b1;
    #2;
    checks++; if (ctl_obs !== 4'b0000) begin errors++; $display("FAIL halt_rst_ctl: got %b expected 0000", ctl_obs); end
    tick();
    $display("test_halt done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_use();
    test_dmiss();
    test_dhit_first();
    test_redirect();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
